cordic_ac_ph: RTL and testbench

Amplitude/phase stage directly downstream of the serial single-bin DFT core (serial_fft_coral). Captures the per-channel re/im accumulator pair when the frame completes. Converts each pair serially, one channel at a time, with an iterative vectoring-mode CORDIC. Emits a gain-compensated amplitude and a phase in binary-angle format per channel.

---
 rtl/ac_ph_pkg.sv | 41 ++++
 rtl/cordic_vec_step.sv | 39 +++
 rtl/cordic_ac_ph.sv | 182 ++++++++++++++++++
 tb/tb_cordic_ac_ph.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_ph_pkg.sv
// Shared types and constants for the amplitude/phase CORDIC stage.
// Holds the FSM state type, the gain-compensation constant and the arctangent table.
package ac_ph_pkg;

  typedef enum logic [1:0] {StIdle, StPre, StRot, StOut} state_e;

  // 1/K for the CORDIC gain in Q15 (0.60725).
  localparam int unsigned KINV_Q15 = 19898;

  // round(atan(2^-i)/pi * 2^(ph_width-1)); base table is at 2^15 full scale.
  function automatic int atan_lut(input int i, input int ph_width);
    int v;
    int sh;
    case (i)
      0:       v = 8192;
      1:       v = 4836;
      2:       v = 2555;
      3:       v = 1297;
      4:       v = 651;
      5:       v = 326;
      6:       v = 163;
      7:       v = 81;
      8:       v = 41;
      9:       v = 20;
      10:      v = 10;
      11:      v = 5;
      12:      v = 3;
      13:      v = 1;
      14:      v = 1;
      default: v = 0;
    endcase
    if (ph_width < 16) begin
      sh = 16 - ph_width;
      v  = (v + (1 << (sh - 1))) >>> sh;
    end else if (ph_width > 16) begin
      v = v << (ph_width - 16);
    end
    return v;
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One vectoring-mode CORDIC micro-rotation, purely combinational.
// Drives y towards zero while accumulating the rotated angle in z.
module cordic_vec_step
  import ac_ph_pkg::*;
#(
  parameter int unsigned XW       = 34,
  parameter int unsigned ZW       = 17,
  parameter int unsigned PH_WIDTH = 16,
  parameter int unsigned IW       = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [IW-1:0] iter_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [ZW-1:0] atan_i;

  always_comb begin
    atan_i = ZW'(atan_lut(int'(iter_i), int'(PH_WIDTH)));
    xs     = x_i >>> iter_i;
    ys     = y_i >>> iter_i;
    if (!y_i[XW-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_ac_ph.sv
// Captures per-channel re/im at frame end and converts each channel in turn to a
// gain-compensated amplitude and binary-angle phase with an iterative CORDIC.
module cordic_ac_ph
  import ac_ph_pkg::*;
#(
  parameter int unsigned S_WIDTH  = 32,
  parameter int unsigned PH_WIDTH = 16,
  parameter int unsigned CHANELS  = 2,
  parameter int unsigned ITER     = 16,
  localparam int unsigned CW      = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_i,
  input  logic [CHANELS-1:0][S_WIDTH-1:0]  re,
  input  logic [CHANELS-1:0][S_WIDTH-1:0]  im,
  output logic                             ready_o,
  output logic [S_WIDTH-1:0]               amp,
  output logic signed [PH_WIDTH-1:0]       phase,
  output logic [CW-1:0]                    ch_o,
  output logic                             valid_o,
  output logic                             done,
  output logic                             overrun
);

  localparam int unsigned XW = S_WIDTH + 2;
  localparam int unsigned ZW = PH_WIDTH + 1;
  localparam int unsigned PW = S_WIDTH + 18;
  localparam int unsigned IW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic signed [ZW-1:0] ZPI  = ZW'(1) << (PH_WIDTH - 1);
  localparam logic signed [PW-1:0] KINV = PW'(KINV_Q15);

  state_e state_q, state_d;

  logic [CHANELS-1:0][S_WIDTH-1:0] re_q, im_q;
  logic [CW-1:0]                   ch_q;
  logic [IW-1:0]                   iter_q;
  logic signed [XW-1:0]            x_q, y_q;
  logic signed [ZW-1:0]            z_q;
  logic                            zero_q;

  logic [S_WIDTH-1:0]              amp_q;
  logic signed [PH_WIDTH-1:0]      phase_q;
  logic [CW-1:0]                   ch_out_q;
  logic                            valid_q, done_q, overrun_q;

  logic cap_en, pre_en, rot_en, out_en, ovr;
  logic last_ch;

  logic signed [S_WIDTH-1:0] re_sel, im_sel;
  logic signed [XW-1:0]      pre_x, pre_y, x_n, y_n;
  logic signed [ZW-1:0]      pre_z, z_n;
  logic                      pre_zero;
  logic [S_WIDTH-1:0]        amp_d;
  logic signed [PH_WIDTH-1:0] phase_d;

  assign last_ch = (ch_q == CW'(CHANELS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i) state_d = StPre;
      StPre:   state_d = StRot;
      StRot:   if (iter_q == IW'(ITER - 1)) state_d = StOut;
      StOut:   state_d = last_ch ? StIdle : StPre;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_o = (state_q == StIdle);
    cap_en  = ready_o && valid_i;
    ovr     = !ready_o && valid_i;
    pre_en  = (state_q == StPre);
    rot_en  = (state_q == StRot);
    out_en  = (state_q == StOut);
  end

  // Fold the left half-plane onto the right so the micro-rotations converge.
  always_comb begin
    re_sel   = re_q[ch_q];
    im_sel   = im_q[ch_q];
    pre_zero = (re_sel == '0) && (im_sel == '0);
    pre_x    = XW'(re_sel);
    pre_y    = XW'(im_sel);
    pre_z    = '0;
    if (re_sel[S_WIDTH-1]) begin
      pre_x = -XW'(re_sel);
      pre_y = -XW'(im_sel);
      pre_z = im_sel[S_WIDTH-1] ? -ZPI : ZPI;
    end
  end

  cordic_vec_step #(
    .XW       (XW),
    .ZW       (ZW),
    .PH_WIDTH (PH_WIDTH),
    .IW       (IW)
  ) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .iter_i (iter_q),
    .x_o    (x_n),
    .y_o    (y_n),
    .z_o    (z_n)
  );

  // z wraps into PH_WIDTH bits, so +pi reads as -2^(PH_WIDTH-1).
  always_comb begin
    amp_d   = S_WIDTH'((PW'(x_q) * KINV) >>> 15);
    phase_d = z_q[PH_WIDTH-1:0];
    if (zero_q) begin
      amp_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re_q      <= '0;
      im_q      <= '0;
      ch_q      <= '0;
      iter_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      zero_q    <= 1'b0;
      amp_q     <= '0;
      phase_q   <= '0;
      ch_out_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= out_en;
      done_q    <= out_en && last_ch;
      overrun_q <= ovr;
      if (cap_en) begin
        re_q <= re;
        im_q <= im;
        ch_q <= '0;
      end
      if (pre_en) begin
        x_q    <= pre_x;
        y_q    <= pre_y;
        z_q    <= pre_z;
        zero_q <= pre_zero;
        iter_q <= '0;
      end
      if (rot_en) begin
        x_q    <= x_n;
        y_q    <= y_n;
        z_q    <= z_n;
        iter_q <= iter_q + IW'(1);
      end
      if (out_en) begin
        amp_q    <= amp_d;
        phase_q  <= phase_d;
        ch_out_q <= ch_q;
        if (!last_ch) ch_q <= ch_q + CW'(1);
      end
    end
  end

  assign amp     = amp_q;
  assign phase   = phase_q;
  assign ch_o    = ch_out_q;
  assign valid_o = valid_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_cordic_ac_ph.sv
// Bench for cordic_ac_ph: a timing/real-arithmetic model checked every cycle,
// plus exact per-vector expectations for small directed inputs.
module tb_cordic_ac_ph;

  localparam int S_WIDTH  = 32;
  localparam int PH_WIDTH = 16;
  localparam int CHANELS  = 2;
  localparam int ITER     = 16;
  localparam int PITCH    = ITER + 2;
  localparam real PI      = 3.14159265358979;
  localparam real KGAIN   = 1.6467602581;
  localparam real HALFSC  = 32768.0;

  logic clk = 1'b0;
  logic rst, valid_i;
  logic [CHANELS-1:0][S_WIDTH-1:0] re, im;
  logic ready_o;
  logic [S_WIDTH-1:0] amp;
  logic signed [PH_WIDTH-1:0] phase;
  logic [0:0] ch_o;
  logic valid_o, done, overrun;

  always #5 clk = ~clk;

  cordic_ac_ph #(
    .S_WIDTH  (S_WIDTH),
    .PH_WIDTH (PH_WIDTH),
    .CHANELS  (CHANELS),
    .ITER     (ITER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .re      (re),
    .im      (im),
    .ready_o (ready_o),
    .amp     (amp),
    .phase   (phase),
    .ch_o    (ch_o),
    .valid_o (valid_o),
    .done    (done),
    .overrun (overrun)
  );

  typedef struct {
    longint t;
    int     ch;
    int     re;
    int     im;
    bit     pin;
    longint pamp;
    int     pph;
  } exp_t;

  exp_t   pend[$];
  exp_t   cur;
  longint edge_n   = 0;
  longint end_edge = 0;
  bit     ovr_exp  = 1'b0;
  bit     after_rst = 1'b0;
  bit     started  = 1'b0;
  int     n_cmp    = 0;
  int     n_bad    = 0;

  bit     pin_en [CHANELS];
  longint pin_amp[CHANELS];
  int     pin_ph [CHANELS];

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, req, edge_n);
    end
  endtask

  // Real-valued reference: the truncating shifts limit angular resolution to
  // about one unit of y per step, which only matters for small magnitudes.
  task automatic chk_model(input exp_t e);
    real mag, ang, d, tol_ph, tol_a, a;
    int  ph;
    ph = int'(phase);
    a  = real'(longint'(amp));
    if (e.re == 0 && e.im == 0) begin
      chk("zero amp", longint'(amp), 0);
      chk("zero phase", longint'(ph), 0);
      return;
    end
    mag    = $sqrt(real'(e.re) * real'(e.re) + real'(e.im) * real'(e.im));
    ang    = $atan2(real'(e.im), real'(e.re)) * HALFSC / PI;
    d      = real'(ph) - ang;
    while (d >= HALFSC) d -= 2.0 * HALFSC;
    while (d < -HALFSC) d += 2.0 * HALFSC;
    tol_ph = 4.0 + real'(ITER) * HALFSC / (PI * KGAIN * mag);
    n_cmp++;
    if (d > tol_ph || d < -tol_ph) begin
      n_bad++;
      $display("FAIL ch%0d phase (%0d,%0d): got %0d, expected %0.2f +/- %0.2f",
               e.ch, e.re, e.im, ph, ang, tol_ph);
    end
    tol_a = 2.0 + 1.0e-4 * mag + real'(ITER) * 0.6073;
    n_cmp++;
    if (a - mag > tol_a || mag - a > tol_a) begin
      n_bad++;
      $display("FAIL ch%0d amp (%0d,%0d): got %0.0f, expected %0.2f +/- %0.2f",
               e.ch, e.re, e.im, a, mag, tol_a);
    end
  endtask

  // Model: frame acceptance, busy window and result timing.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      pend.delete();
      end_edge  = edge_n;
      ovr_exp   = 1'b0;
      after_rst = 1'b1;
      started   = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (valid_i && edge_n > end_edge) begin
        end_edge = edge_n + longint'(CHANELS * PITCH);
        ovr_exp  = 1'b0;
        for (int k = 0; k < CHANELS; k++) begin
          exp_t e;
          e.t    = edge_n + longint'((k + 1) * PITCH);
          e.ch   = k;
          e.re   = int'(re[k]);
          e.im   = int'(im[k]);
          e.pin  = pin_en[k];
          e.pamp = pin_amp[k];
          e.pph  = pin_ph[k];
          pend.push_back(e);
        end
      end else begin
        ovr_exp = valid_i;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit ev;
      ev = (pend.size() > 0) && (pend[0].t == edge_n);
      chk("valid_o", longint'(valid_o), longint'(ev));
      chk("done", longint'(done), longint'(ev && pend[0].ch == CHANELS - 1));
      chk("ready_o", longint'(ready_o), longint'(edge_n >= end_edge));
      chk("overrun", longint'(overrun), longint'(ovr_exp));
      if (after_rst) begin
        chk("reset amp", longint'(amp), 0);
        chk("reset phase", longint'(int'(phase)), 0);
        chk("reset ch_o", longint'(ch_o), 0);
      end
      if (ev) begin
        cur = pend.pop_front();
        chk("ch_o", longint'(ch_o), longint'(cur.ch));
        chk_model(cur);
        if (cur.pin) begin
          chk("exact amp", longint'(amp), cur.pamp);
          chk("exact phase", longint'(int'(phase)), longint'(cur.pph));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int r, input int i, input bit p,
                        input longint pa, input int pp);
    re[k]      = S_WIDTH'(r);
    im[k]      = S_WIDTH'(i);
    pin_en[k]  = p;
    pin_amp[k] = pa;
    pin_ph[k]  = pp;
  endtask

  task automatic pulse_valid();
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 200);
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", k);
    end
  endtask

  initial begin
    int r0, i0, r1, i1;
    rst     = 1'b1;
    valid_i = 1'b0;
    re      = '0;
    im      = '0;
    for (int k = 0; k < CHANELS; k++) begin
      pin_en[k] = 1'b0; pin_amp[k] = 0; pin_ph[k] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Cardinal angles.
    set_ch(0, 1000, 0, 1'b1, 1001, 12);
    set_ch(1, 0, 1000, 1'b1, 1000, 16392);
    pulse_valid();
    wait_done();
    tick();

    // Negative axis / third quadrant, with a stray valid_i mid-frame.
    set_ch(0, -1000, 0, 1'b1, 1001, -32756);
    set_ch(1, -1000, -1000, 1'b1, 1417, -24580);
    pulse_valid();
    repeat (5) tick();
    re = {32'd7, 32'd9};
    im = {32'd3, 32'd1};
    pulse_valid();
    wait_done();

    // Next frame in the cycle after done: extremes.
    tick();
    set_ch(0, int'(32'h8000_0000), int'(32'h8000_0000), 1'b0, 0, 0);
    set_ch(1, 0, 0, 1'b1, 0, 0);
    pulse_valid();
    wait_done();
    tick();

    // Reset in the middle of channel 0 rotations, with a coincident valid_i.
    set_ch(0, 123456, -654321, 1'b0, 0, 0);
    set_ch(1, -5, 77, 1'b0, 0, 0);
    pulse_valid();
    repeat (8) tick();
    rst     = 1'b1;
    valid_i = 1'b1;
    tick();
    rst     = 1'b0;
    valid_i = 1'b0;
    repeat (3) tick();
    set_ch(0, 1000, 0, 1'b1, 1001, 12);
    set_ch(1, 0, 1000, 1'b1, 1000, 16392);
    pulse_valid();
    wait_done();
    tick();

    // Random sweep: 1000 vectors, two per frame.
    for (int n = 0; n < 500; n++) begin
      r0 = $urandom;
      i0 = $urandom;
      r1 = $urandom;
      i1 = $urandom;
      set_ch(0, r0, i0, 1'b0, 0, 0);
      set_ch(1, r1, i1, 1'b0, 0, 0);
      pulse_valid();
      wait_done();
      tick();
    end
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
